// File: rtl/cpu_pkg.sv
// Shared widths and enumerations for the 9-bit single-cycle core.
package cpu_pkg;

  localparam int PC_W    = 7;
  localparam int INSTR_W = 9;

  typedef enum logic [2:0] {
    ADD, SUB, AND, LDI, LDR, STR, BRZ, JMP_HALT
  } op_e;

  typedef enum logic [1:0] {
    IDLE, RUN, HALTED
  } fetch_state_e;

endpackage

// File: rtl/branch_resolve.sv
// Combinational next-PC resolution for BRZ/JMP/HALT; everything else falls through to pc+1.
module branch_resolve
  import cpu_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  input  logic               z_flag,
  input  logic [PC_W-1:0]    pc,
  output logic [PC_W-1:0]    next_pc,
  output logic               is_halt
);

  op_e             op;
  logic [PC_W-1:0] tgt;

  assign op  = op_e'(instr[8:6]);
  assign tgt = PC_W'(instr[5:0]);

  always_comb begin
    is_halt = 1'b0;
    next_pc = pc + 1'b1;
    case (op)
      JMP_HALT: begin
        // A zero target on the jump opcode is the HALT encoding.
        if (tgt == '0) begin
          is_halt = 1'b1;
          next_pc = pc;
        end else begin
          next_pc = tgt;
        end
      end
      BRZ: begin
        if (z_flag) next_pc = tgt;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/fetch_ctrl.sv
// PC and run-control stage: start/done handshake, retired-instruction counter, execute enable.
module fetch_ctrl
  import cpu_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr,
  input  logic               z_flag,
  output logic [PC_W-1:0]    pc,
  output logic               exec_en,
  output logic               done,
  output logic [CNT_W-1:0]   retired
);

  fetch_state_e     state_q;
  logic [PC_W-1:0]  pc_q;
  logic [PC_W-1:0]  pc_d;
  logic [CNT_W-1:0] retired_q;
  logic             is_halt;

  branch_resolve u_branch_resolve (
    .instr   (instr),
    .z_flag  (z_flag),
    .pc      (pc_q),
    .next_pc (pc_d),
    .is_halt (is_halt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      retired_q <= '0;
    end else begin
      case (state_q)
        IDLE, HALTED: begin
          if (start) begin
            state_q   <= RUN;
            pc_q      <= '0;
            retired_q <= '0;
          end
        end
        RUN: begin
          pc_q <= pc_d;
          if (is_halt) begin
            state_q <= HALTED;
          end else if (retired_q != '1) begin
            retired_q <= retired_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Decoded directly from state and the current instruction so HALT suppresses its own commit.
  assign exec_en = (state_q == RUN) && !is_halt;
  assign done    = (state_q == HALTED);
  assign pc      = pc_q;
  assign retired = retired_q;

endmodule

// File: doc/fetch_ctrl.md
# fetch_ctrl

Program-counter and run-control stage for the 9-bit single-cycle core. It owns the PC that addresses `inst_rom`, sequences the start/done handshake seen by `TopLevel`, and resolves BRZ/JMP/HALT. It sits directly upstream of decode/register file/data memory: it produces the instruction address and the execute enable that gates every architectural write.

## Interface
- `PC_W`, 7, PC width; ROM depth is 2^PC_W = 128.
- `INSTR_W`, 9, instruction width.
- `CNT_W`, 16, retired-instruction counter width.
- `clk`  in  1  core clock.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  run request; it is sampled on the rising edge.
- `instr`  in  INSTR_W  combinational `inst_rom` output for the current `pc`.
- `z_flag`  in  1  registered zero flag from the ALU result of the last ALU op.
- `pc`  out  PC_W  instruction address presented to `inst_rom`.
- `exec_en`  out  1  the current instruction commits (writes to reg/mem allowed).
- `done`  out  1  program has halted; level, held until the next start.
- `retired`  out  CNT_W  count of instructions retired since the last start.

## Operation
- Decode fields: `op = instr[8:6]` and `tgt = instr[5:0]`. `tgt` is zero-extended to PC_W.
- HALT is `op==3'b111 && tgt==0`. JMP is `op==3'b111 && tgt!=0`. BRZ is `op==3'b110`. Every other opcode is sequential.
- FSM states: IDLE, RUN, HALTED.
- **IDLE:**
  - `pc` is held at 0, `exec_en=0`, `done=0`.
  - `start=1` at an edge moves to RUN with `pc=0` and `retired=0`.
- **RUN:**
  - `exec_en=1` except when the current instruction is HALT.
  - Next PC:
    - HALT: `pc` is held.
    - JMP: `pc=tgt`.
    - BRZ with `z_flag=1`: `pc=tgt`.
    - Otherwise: `pc+1`, wrapping from 127 to 0.
  - `retired` increments for every non-HALT instruction and saturates at 2^CNT_W-1.
  - HALT moves to HALTED.
  - `start` is ignored while in RUN.
- **HALTED:**
  - `done=1`, `exec_en=0`, and `pc`/`retired` are frozen.
  - `start=1` restarts: next state RUN, `pc=0`, `retired=0`, `done=0`.
- BRZ with `z_flag=0` falls through to `pc+1`.
- `z_flag` is consumed only on BRZ.
- Reset (`reset=0`) at any time forces IDLE, `pc=0`, `done=0`, `exec_en=0`, `retired=0` immediately, without waiting for a clock edge. This includes reset asserted mid-program.

## Timing
- All state (`state`, `pc`, `retired`) is registered on `posedge clk` / `negedge reset`.
- `done` and `exec_en` are decoded from the state register plus the current `instr`. They have no extra pipeline stage.
- Start latency: with `start` sampled at edge N, the instruction at ROM[0] executes in the cycle after edge N. Its `exec_en=1` is visible immediately after N.
- Branch latency: a taken JMP/BRZ at edge N causes ROM[tgt] to be presented after N. There is no delay slot and no bubble.
- HALT latency: with HALT presented in the cycle before edge N, `done=1` from edge N onward.
- A single-cycle `start` pulse is sufficient. A `start` held high is edge-insensitive; it restarts again on every edge spent in HALTED.

## Structure
- Shared package `cpu_pkg` holds:
  - `PC_W`, `INSTR_W`
  - opcode enum `op_e` (ADD, SUB, AND, LDI, LDR, STR, BRZ, JMP_HALT)
  - `fetch_state_e` (IDLE, RUN, HALTED)
- One combinational sub-module, `branch_resolve`, takes `instr`, `z_flag` and `pc` and produces `next_pc` and `is_halt`.
- The FSM and counters live in `fetch_ctrl`.

## Test plan
- **Reset and start:** `reset=0` for 2 cycles, then release. Require `pc=0`, `done=0`, `exec_en=0`. Pulse `start`; `exec_en=1` with `pc=0`.
- **Sequential plus HALT:** ROM[0..2] = LDI, LDI, 9'b111000000. Require `pc` to go 0,1,2, then `done=1` held, `retired=2`, and `exec_en=0` on the HALT cycle.
- **BRZ:**
  - `z_flag=1` with ROM[2]=9'b110000101: `pc` goes 2→5.
  - Repeat with `z_flag=0`: `pc` goes 2→3.
- **JMP and wrap:**
  - ROM[0]=9'b111000011: `pc` goes 0→3.
  - Program of 128 ADDs with no HALT: `pc` goes 127→0 and `retired` keeps counting.
- **Restart and mid-run reset:**
  - `start` in HALTED: `done` drops and `pc=0`.
  - `reset=0` asynchronously mid-RUN between edges: `pc=0`, `done=0` immediately, and `start` is required to resume.
